data_sampling_mv: RTL and testbench
===================================

// Module: data_sampling_mv
// PURPOSE
//  Parametrised majority-vote sampler for the UART RX path: takes NSAMP samples
//  of RX_IN centred on mid-bit (edge_cnt window from the RX edge counter), votes,
//  and outputs the bit with a one-cycle valid strobe plus noise and config flags.
//  Sits between the RX edge/bit counter and the parity/start/stop checkers.
//  Supersedes the fixed 3-sample sampler.
// PARAMETERS
//  PRESCALE_W  6  width of Prescale and edge_cnt
//  NSAMP       3  samples per bit; odd, 1..7 (even/out-of-range -> elaboration error)
// PORTS
//  CLK          in   1           RX oversampling clock
//  RST          in   1           async reset, active low
//  Prescale     in   PRESCALE_W  oversampling ratio (edge_cnt counts 0..Prescale-1)
//  RX_IN        in   1           serial line, already synchronised to CLK
//  dat_samp_en  in   1           sampling enable from RX FSM
//  edge_cnt     in   PRESCALE_W  current oversample edge index within the bit
//  sampled_bit  out  1           voted bit value
//  samp_valid   out  1           1-cycle pulse: sampled_bit/noise_err updated
//  noise_err    out  1           samples of last bit not unanimous
//  cfg_err      out  1           Prescale cannot hold the sample window
// BEHAVIOUR
//  - Reset (RST=0, async): sampled_bit=1 (idle line), samp_valid=0, noise_err=0,
//    cfg_err=0, ones counter=0, sample counter=0.
//  - H=(NSAMP-1)/2, C=Prescale>>1 (floor), FIRST=C-H, LAST=C+H; all arithmetic in
//    PRESCALE_W+1 bits, no wrap.
//  - cfg_err registered every cycle: 1 when C<H or LAST>Prescale-1, else 0.
//    While cfg_err=1 (current cycle's combinational condition) no sample is taken
//    and samp_valid stays 0.
//  - Window states: IDLE, ACC. IDLE->ACC when dat_samp_en & edge_cnt==FIRST:
//    ones<=RX_IN, n<=1. In ACC, each cycle dat_samp_en & FIRST<edge_cnt<LAST:
//    ones+=RX_IN, n+=1. Cycles with en=1 and edge_cnt unchanged outside this rule
//    take no extra samples (edge_cnt advances once per CLK by contract).
//  - Decision at dat_samp_en & edge_cnt==LAST in ACC (or IDLE when NSAMP=1, where
//    FIRST==LAST): total=ones+RX_IN (current sample included, same cycle);
//    registered next edge: sampled_bit<=(total>H), noise_err<=(total!=0 &&
//    total!=NSAMP), samp_valid<=1; state->IDLE, ones/n cleared.
//    Latency: outputs valid 1 CLK after the LAST edge.
//  - samp_valid is 1 for exactly one cycle; sampled_bit and noise_err hold
//    between decisions.
//  - dat_samp_en falling while in ACC, or edge_cnt leaving window without
//    reaching LAST: abort -> IDLE, accumulators cleared, no samp_valid, outputs
//    hold.
//  - edge_cnt==FIRST while in ACC (re-entry): restart accumulation with this
//    sample.
//  - Prescale change mid-window: window recomputed combinationally; if current
//    edge_cnt is outside the new window -> abort as above.
//  - Reset mid-window: immediate return to reset values, no pulse.
// TESTING
//  1 NSAMP=3, Prescale=8, RX_IN=1 at edge 3,4,5 -> edge 6 cycle: sampled_bit=1,
//    samp_valid=1, noise_err=0
//  2 NSAMP=5, Prescale=16, samples 0,1,0,1,0 at edges 6..10 -> sampled_bit=0,
//    noise_err=1, one valid pulse
//  3 NSAMP=7, Prescale=8: window 1..7 -> cfg_err=0; Prescale=4 -> cfg_err=1,
//    no samp_valid over a full bit
//  4 NSAMP=3, Prescale=8, dat_samp_en dropped at edge 4 -> no samp_valid,
//    sampled_bit unchanged; next full bit decides correctly
//  5 RST asserted at edge 4 with sampled_bit=0 -> sampled_bit=1, samp_valid=0,
//    noise_err=0 immediately
//  6 NSAMP=1, Prescale=8, RX_IN=0 only at edge 4 -> sampled_bit=0, noise_err=0

Source files
------------

// File: rtl/data_sampling_mv.sv
// Majority-vote RX bit sampler: votes NSAMP samples centred on mid-bit and
// emits the bit with a one-cycle valid strobe, a noise flag and a config flag.
module data_sampling_mv #(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned NSAMP      = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  RX_IN,
    input  logic                  dat_samp_en,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  sampled_bit,
    output logic                  samp_valid,
    output logic                  noise_err,
    output logic                  cfg_err
);

    localparam int unsigned W1   = PRESCALE_W + 1;
    localparam int unsigned CW   = 3;
    localparam int unsigned HALF = (NSAMP - 1) / 2;

    if ((NSAMP % 2) == 0 || NSAMP < 1 || NSAMP > 7) begin : g_bad_nsamp
        $error("data_sampling_mv: NSAMP must be odd and within 1..7");
    end

    typedef enum logic [0:0] {IDLE, ACC} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  ones, ones_nxt;
    logic [CW-1:0]  n, n_nxt;
    logic           bit_nxt, valid_nxt, noise_nxt;

    logic [W1-1:0]  ps_c, ctr_c, first_c, last_c, ec_c;
    logic [CW-1:0]  total_c;
    logic           cfg_c, take_c, at_first_c, at_last_c, in_mid_c;

    // Sample window around mid-bit, one bit wider than Prescale so nothing wraps
    assign ps_c       = W1'(Prescale);
    assign ctr_c      = ps_c >> 1;
    assign first_c    = ctr_c - W1'(HALF);
    assign last_c     = ctr_c + W1'(HALF);
    assign ec_c       = W1'(edge_cnt);
    assign cfg_c      = (ctr_c < W1'(HALF)) || (last_c >= ps_c);
    assign take_c     = dat_samp_en && !cfg_c;
    assign at_first_c = (ec_c == first_c);
    assign at_last_c  = (ec_c == last_c);
    assign in_mid_c   = (ec_c > first_c) && (ec_c < last_c);
    assign total_c    = ones + CW'(RX_IN);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            ones        <= '0;
            n           <= '0;
            sampled_bit <= 1'b1;
            samp_valid  <= 1'b0;
            noise_err   <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ones        <= ones_nxt;
            n           <= n_nxt;
            sampled_bit <= bit_nxt;
            samp_valid  <= valid_nxt;
            noise_err   <= noise_nxt;
            cfg_err     <= cfg_c;
        end
    end

    // Window FSM; the decision cycle folds the current sample into the vote
    always_comb begin
        state_nxt = state;
        ones_nxt  = ones;
        n_nxt     = n;
        bit_nxt   = sampled_bit;
        noise_nxt = noise_err;
        valid_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (take_c && at_first_c) begin
                    if (at_last_c) begin
                        bit_nxt   = (total_c > CW'(HALF));
                        noise_nxt = (total_c != '0) && (total_c != CW'(NSAMP));
                        valid_nxt = 1'b1;
                        ones_nxt  = '0;
                        n_nxt     = '0;
                    end else begin
                        state_nxt = ACC;
                        ones_nxt  = CW'(RX_IN);
                        n_nxt     = CW'(1);
                    end
                end
            end
            ACC: begin
                if (!take_c) begin
                    state_nxt = IDLE;
                    ones_nxt  = '0;
                    n_nxt     = '0;
                end else if (at_first_c) begin
                    ones_nxt  = CW'(RX_IN);
                    n_nxt     = CW'(1);
                end else if (at_last_c) begin
                    bit_nxt   = (total_c > CW'(HALF));
                    noise_nxt = (total_c != '0) && (total_c != CW'(NSAMP));
                    valid_nxt = 1'b1;
                    state_nxt = IDLE;
                    ones_nxt  = '0;
                    n_nxt     = '0;
                end else if (in_mid_c) begin
                    ones_nxt  = total_c;
                    n_nxt     = n + CW'(1);
                end else begin
                    state_nxt = IDLE;
                    ones_nxt  = '0;
                    n_nxt     = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                ones_nxt  = '0;
                n_nxt     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_data_sampling_mv.sv
// Scoreboard bench for data_sampling_mv: four instances (NSAMP 3,5,7,1) driven
// with directed bits; expected votes are queued and checked on each valid pulse.
module tb_data_sampling_mv;

    logic            CLK = 1'b0;
    logic            RST;
    logic [3:0][5:0] ps;
    logic [3:0][5:0] ec;
    logic [3:0]      rx, en, sb, sv, ne, ce;

    typedef struct {
        int   idx;
        logic b;
        logic n;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   fails  = 0;

    always #5 CLK = ~CLK;

    data_sampling_mv #(.PRESCALE_W(6), .NSAMP(3)) u_n3 (
        .CLK(CLK), .RST(RST), .Prescale(ps[0]), .RX_IN(rx[0]), .dat_samp_en(en[0]),
        .edge_cnt(ec[0]), .sampled_bit(sb[0]), .samp_valid(sv[0]), .noise_err(ne[0]),
        .cfg_err(ce[0]));
    data_sampling_mv #(.PRESCALE_W(6), .NSAMP(5)) u_n5 (
        .CLK(CLK), .RST(RST), .Prescale(ps[1]), .RX_IN(rx[1]), .dat_samp_en(en[1]),
        .edge_cnt(ec[1]), .sampled_bit(sb[1]), .samp_valid(sv[1]), .noise_err(ne[1]),
        .cfg_err(ce[1]));
    data_sampling_mv #(.PRESCALE_W(6), .NSAMP(7)) u_n7 (
        .CLK(CLK), .RST(RST), .Prescale(ps[2]), .RX_IN(rx[2]), .dat_samp_en(en[2]),
        .edge_cnt(ec[2]), .sampled_bit(sb[2]), .samp_valid(sv[2]), .noise_err(ne[2]),
        .cfg_err(ce[2]));
    data_sampling_mv #(.PRESCALE_W(6), .NSAMP(1)) u_n1 (
        .CLK(CLK), .RST(RST), .Prescale(ps[3]), .RX_IN(rx[3]), .dat_samp_en(en[3]),
        .edge_cnt(ec[3]), .sampled_bit(sb[3]), .samp_valid(sv[3]), .noise_err(ne[3]),
        .cfg_err(ce[3]));

    // Monitor: every valid pulse must match the oldest queued expectation
    always @(negedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (sv[i] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid dut=%0d got bit=%0b noise=%0b required no pulse",
                             i, sb[i], ne[i]);
                end else begin
                    e = exp_q.pop_front();
                    if (e.idx != i || sb[i] !== e.b || ne[i] !== e.n) begin
                        fails++;
                        $display("FAIL vote dut=%0d got bit=%0b noise=%0b required dut=%0d bit=%0b noise=%0b",
                                 i, sb[i], ne[i], e.idx, e.b, e.n);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got=%0b required=%0b", name, act, req);
        end
    endtask

    task automatic expect_bit(input int idx, input logic b, input logic n);
        exp_t x;
        x.idx = idx;
        x.b   = b;
        x.n   = n;
        exp_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One bit period: rx_v/en_v give RX_IN and dat_samp_en per edge index
    task automatic run_bit(input int idx, input int ps_v, input logic [63:0] rx_v,
                           input logic [63:0] en_v);
        for (int k = 0; k < ps_v; k++) begin
            ec[idx] = 6'(k);
            rx[idx] = rx_v[k];
            en[idx] = en_v[k];
            tick();
        end
        en[idx] = 1'b0;
        ec[idx] = 6'd0;
        rx[idx] = 1'b1;
        repeat (2) tick();
    endtask

    localparam logic [63:0] ALL1 = {64{1'b1}};

    initial begin
        RST   = 1'b1;
        ps[0] = 6'd8;
        ps[1] = 6'd16;
        ps[2] = 6'd8;
        ps[3] = 6'd8;
        ec    = '0;
        rx    = '1;
        en    = '0;
        #2 RST = 1'b0;
        #10;
        chk("rst_sampled_bit", sb[0], 1'b1);
        chk("rst_samp_valid", sv[0], 1'b0);
        chk("rst_noise_err", ne[0], 1'b0);
        chk("rst_cfg_err", ce[0], 1'b0);
        @(posedge CLK);
        #1 RST = 1'b1;
        tick();
        chk("cfg_n3_ps8", ce[0], 1'b0);

        // NSAMP=3, Prescale=8: window 3..5
        expect_bit(0, 1'b1, 1'b0);
        run_bit(0, 8, ALL1, ALL1);
        expect_bit(0, 1'b1, 1'b1);
        run_bit(0, 8, ~(64'd1 << 4), ALL1);
        expect_bit(0, 1'b0, 1'b1);
        run_bit(0, 8, ~64'h18, ALL1);
        expect_bit(0, 1'b0, 1'b0);
        run_bit(0, 8, 64'h0, ALL1);

        // Smallest Prescale that still holds a 3-sample window, and one below it
        ps[0] = 6'd3;
        tick();
        chk("cfg_n3_ps3", ce[0], 1'b0);
        expect_bit(0, 1'b1, 1'b0);
        run_bit(0, 3, ALL1, ALL1);
        ps[0] = 6'd2;
        tick();
        chk("cfg_n3_ps2", ce[0], 1'b1);
        run_bit(0, 2, 64'h0, ALL1);
        ps[0] = 6'd8;
        tick();

        // NSAMP=5, Prescale=16: samples 0,1,0,1,0 at edges 6..10
        expect_bit(1, 1'b0, 1'b1);
        run_bit(1, 16, ~64'h540, ALL1);

        // NSAMP=7: Prescale=8 fits (1..7), 4 and 6 do not
        chk("cfg_n7_ps8", ce[2], 1'b0);
        expect_bit(2, 1'b1, 1'b0);
        run_bit(2, 8, ALL1, ALL1);
        ps[2] = 6'd4;
        tick();
        chk("cfg_n7_ps4", ce[2], 1'b1);
        run_bit(2, 4, 64'h0, ALL1);
        ps[2] = 6'd6;
        tick();
        chk("cfg_n7_ps6", ce[2], 1'b1);
        run_bit(2, 6, 64'h0, ALL1);

        // Enable dropped at edge 4 aborts the bit; the next full bit decides
        run_bit(0, 8, 64'h0, ~(64'd1 << 4));
        chk("abort_holds_bit", sb[0], 1'b1);
        expect_bit(0, 1'b0, 1'b0);
        run_bit(0, 8, 64'h0, ALL1);
        expect_bit(0, 1'b0, 1'b1);
        run_bit(0, 8, ~64'h18, ALL1);

        // Async reset in the middle of a window
        for (int k = 0; k < 4; k++) begin
            ec[0] = 6'(k);
            rx[0] = 1'b0;
            en[0] = 1'b1;
            tick();
        end
        ec[0] = 6'd4;
        RST   = 1'b0;
        #1;
        chk("midrst_sampled_bit", sb[0], 1'b1);
        chk("midrst_samp_valid", sv[0], 1'b0);
        chk("midrst_noise_err", ne[0], 1'b0);
        en[0] = 1'b0;
        ec[0] = 6'd0;
        rx[0] = 1'b1;
        tick();
        RST = 1'b1;
        repeat (2) tick();

        // NSAMP=1, Prescale=8: single sample at edge 4
        expect_bit(3, 1'b0, 1'b0);
        run_bit(3, 8, ~(64'd1 << 4), ALL1);
        expect_bit(3, 1'b1, 1'b0);
        run_bit(3, 8, ALL1, ALL1);

        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_valid got=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
